product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Stage directly downstream of the registered 8x8 multiplier; consumes its 16-bit products one per cycle.
- Sums each batch of COUNT products into a full-precision sum.
- Presents each finished sum through a valid/ready output handshake.
- Provides the exact reference sum against which the approximate Wallace-tree accumulation path is compared.

Parameters:
- PROD_W, 16, product width (matches multiplier output)
- COUNT, 8, products per batch (>=2)
- CNT_W, $clog2(COUNT), batch counter width
- ACC_W, PROD_W+$clog2(COUNT), sum width; sized so a full batch cannot overflow

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- prod_in  input  PROD_W  product from the multiplier
- prod_valid  input  1  prod_in valid this cycle
- prod_ready  output  1  accumulator can accept prod_in this cycle
- clear  input  1  synchronous abort of the current batch
- sum_out  output  ACC_W  completed batch sum
- sum_valid  output  1  sum_out holds a completed, unconsumed sum
- sum_ready  input  1  downstream accepts sum_out
- batch_cnt  output  CNT_W  products accepted in the current batch

Behaviour:
- Reset (async assert, sync release) puts the block in ACCUM with acc=0, batch_cnt=0, sum_out=0, sum_valid=0. prod_ready is 1 after reset.
- Accept event: prod_valid & prod_ready. Sum handoff: sum_valid & sum_ready.
- States: ACCUM, HOLD.
- ACCUM:
  - prod_ready=1.
  - On accept with batch_cnt<COUNT-1: acc<=acc+zero-extended prod_in; batch_cnt++.
  - On accept with batch_cnt==COUNT-1: sum_out<=acc+prod_in; sum_valid<=1; acc<=0; batch_cnt<=0; go to HOLD.
  - Latency from the last product accepted to sum_valid is 1 cycle.
- HOLD:
  - sum_valid=1; sum_out stable until handoff.
  - prod_ready=sum_ready. This is a combinational path, so back-to-back batches run with no bubble.
  - On handoff with no accept: sum_valid<=0; go to ACCUM.
  - On handoff with accept: sum_valid<=0; acc<=prod_in; batch_cnt<=1; go to ACCUM.
  - If COUNT products would complete while the previous sum is still held: impossible, because accepts in HOLD require sum_ready.
- clear has highest priority and acts in any state:
  - acc<=0; batch_cnt<=0; sum_valid<=0; state<=ACCUM; any prod_in in the same cycle is dropped.
  - sum_out keeps its last value; only sum_valid qualifies it.
- prod_valid while prod_ready=0: the product is not consumed. The upstream stage must hold it.
- Arithmetic: unsigned, zero-extended to ACC_W, no saturation. The worst case COUNT*(2^PROD_W-1) fits in ACC_W.
- rst asserted mid-batch: partial sum and count are discarded immediately, with no output pulse.
- All outputs are registered except prod_ready.

Decomposition:
- Shared package holds:
  - state enum {ACCUM, HOLD}
  - PROD_W default
  - ACC_W derivation function, reused by the approximate-accumulator comparison logic
- Natural sub-module: batch_counter (mod-COUNT up-counter with clear, increment, load-1 and a terminal-count flag).
- Adder and state logic stay in the top module.

Test Plan:
- Reset then 8 consecutive valid products of 1..8 with sum_ready=1 -> sum_valid high 1 cycle after the 8th accept, sum_out=36; next product accepted with no bubble.
- 8 products of 0xFFFF -> sum_out=0x7FFF8 (524280), no wrap; batch_cnt returns to 0.
- Batch completes with sum_ready=0 for 5 cycles -> prod_ready=0 and sum_out=36 stable throughout; on sum_ready=1 the same-cycle product 10 is accepted, batch_cnt=1, and the next batch sum includes it.
- Accept 3 products (100,200,300), assert clear together with a valid product 400, then send 8 ones -> batch_cnt=0 after clear, product 400 dropped, next sum_out=8.
- Assert rst asynchronously mid-cycle after 5 products -> sum_valid, batch_cnt and acc are 0 immediately; after release, 8 products of 2 -> sum_out=16.
- Random prod_valid/sum_ready gaps over 100 batches -> every sum_out matches the scoreboard sum of exactly COUNT accepted products, with no product lost or duplicated.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator and its companion logic.
//   state_e    : accumulator FSM states
//   PROD_W_DEF : default product width (matches the 8x8 multiplier output)
//   COUNT_DEF  : default number of products per batch
//   acc_width  : full-precision sum width for a batch of products
package product_accumulator_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int unsigned PROD_W_DEF = 16;
  localparam int unsigned COUNT_DEF  = 8;

  // Sum width that cannot overflow for COUNT products of prod_w bits each.
  function automatic int unsigned acc_width(input int unsigned prod_w,
                                            input int unsigned count);
    return prod_w + 32'($clog2(count));
  endfunction

endpackage

// File: rtl/product_accumulator_batch_counter.sv
// Mod-COUNT batch counter.
//   clk, rst  : clock, asynchronous active-high reset
//   i_clear   : force count to 0 (highest priority)
//   i_load1   : force count to 1 (first product of a new batch)
//   i_inc     : count up, wrapping to 0 after COUNT-1
//   o_cnt     : registered count
//   o_tc_c    : combinational terminal-count flag (count == COUNT-1)
module product_accumulator_batch_counter #(
  parameter int unsigned COUNT = 8,
  parameter int unsigned CNT_W = $clog2(COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_load1,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc_c
);

  logic [CNT_W-1:0] r_cnt;

  assign o_tc_c = (r_cnt == CNT_W'(COUNT - 1));
  assign o_cnt  = r_cnt;

  // Count register: clear > load-1 > increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load1) begin
      r_cnt <= CNT_W'(1);
    end else if (i_inc) begin
      r_cnt <= o_tc_c ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Full-precision accumulator of multiplier products, COUNT products per batch.
//   clk, rst              : clock, asynchronous active-high reset
//   prod_in/valid/ready   : product input handshake (prod_ready is combinational)
//   clear                 : synchronous abort of the current batch
//   sum_out/valid/ready   : completed batch sum output handshake
//   batch_cnt             : products accepted in the current batch
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned COUNT  = COUNT_DEF,
  parameter int unsigned CNT_W  = $clog2(COUNT),
  parameter int unsigned ACC_W  = acc_width(PROD_W, COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic              clear,
  output logic [ACC_W-1:0]  sum_out,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [CNT_W-1:0]  batch_cnt
);

  state_e             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_sum_out;
  logic               r_sum_valid;

  logic               w_accept;
  logic               w_handoff;
  logic               w_tc;
  logic [ACC_W-1:0]   w_prod_ext;
  logic [ACC_W-1:0]   w_acc_next;

  // In HOLD a new product may only enter in the same cycle the held sum leaves.
  assign prod_ready = (r_state == ACCUM) ? 1'b1 : sum_ready;
  assign w_accept   = prod_valid & prod_ready & ~clear;
  assign w_handoff  = r_sum_valid & sum_ready;
  assign w_prod_ext = ACC_W'(prod_in);
  assign w_acc_next = r_acc + w_prod_ext;

  assign sum_out    = r_sum_out;
  assign sum_valid  = r_sum_valid;

  product_accumulator_batch_counter #(
    .COUNT (COUNT),
    .CNT_W (CNT_W)
  ) u_batch_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clear (clear),
    .i_load1 (w_accept & (r_state == HOLD)),
    .i_inc   (w_accept & (r_state == ACCUM)),
    .o_cnt   (batch_cnt),
    .o_tc_c  (w_tc)
  );

  // Accumulate / hold FSM with registered sum outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_sum_out   <= '0;
      r_sum_valid <= 1'b0;
    end else if (clear) begin
      // sum_out is left as-is; only sum_valid qualifies it.
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_sum_valid <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            if (w_tc) begin
              r_sum_out   <= w_acc_next;
              r_sum_valid <= 1'b1;
              r_acc       <= '0;
              r_state     <= HOLD;
            end else begin
              r_acc <= w_acc_next;
            end
          end
        end
        HOLD: begin
          if (w_handoff) begin
            r_sum_valid <= 1'b0;
            r_state     <= ACCUM;
            // A product accepted alongside the handoff starts the next batch.
            if (w_accept) begin
              r_acc <= w_prod_ext;
            end
          end
        end
        default: begin
          r_state <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator with a queue-based reference model.
module tb_product_accumulator;

  localparam int unsigned PROD_W = 16;
  localparam int unsigned COUNT  = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned ACC_W  = 19;

  logic              clk = 1'b0;
  logic              rst;
  logic [PROD_W-1:0] prod_in;
  logic              prod_valid;
  logic              prod_ready;
  logic              clear;
  logic [ACC_W-1:0]  sum_out;
  logic              sum_valid;
  logic              sum_ready;
  logic [CNT_W-1:0]  batch_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  product_accumulator #(
    .PROD_W (PROD_W),
    .COUNT  (COUNT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .clear      (clear),
    .sum_out    (sum_out),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .batch_cnt  (batch_cnt)
  );

  // Reference model: list of accepted products in the open batch, plus the
  // sum currently being offered downstream.
  int unsigned      m_parts[$];
  logic             m_hold;
  logic [ACC_W-1:0] m_sum;
  int               m_batches;

  always @(posedge clk or posedge rst) begin
    logic ready;
    longint total;
    if (rst) begin
      m_parts.delete();
      m_hold = 1'b0;
      m_sum  = '0;
    end else if (clear) begin
      m_parts.delete();
      m_hold = 1'b0;
    end else begin
      ready = !m_hold || sum_ready;
      if (m_hold && sum_ready) m_hold = 1'b0;
      if (prod_valid && ready) begin
        m_parts.push_back(int'(prod_in));
        if (m_parts.size() == COUNT) begin
          total = 0;
          foreach (m_parts[k]) total += longint'(m_parts[k]);
          m_sum  = ACC_W'(total);
          m_hold = 1'b1;
          m_batches++;
          m_parts.delete();
        end
      end
    end
  end

  task automatic drive(input logic v, input int p, input logic r, input logic c);
    @(posedge clk);
    #1;
    prod_valid = v;
    prod_in    = PROD_W'(p);
    sum_ready  = r;
    clear      = c;
    #1;
  endtask

  task automatic flush();
    drive(1'b0, 0, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; prod_valid = 1'b0; prod_in = '0; sum_ready = 1'b0; clear = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (sum_valid !== 1'b0 || sum_out !== '0 || batch_cnt !== '0 || prod_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: sum_valid=%b sum_out=%0d batch_cnt=%0d prod_ready=%b required 0/0/0/1",
               sum_valid, sum_out, batch_cnt, prod_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i + 1, 1'b1, 1'b0);
      n_tests++;
      if (batch_cnt !== CNT_W'(i) || prod_ready !== 1'b1 || sum_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_fill[%0d]: batch_cnt=%0d prod_ready=%b sum_valid=%b required %0d/1/0",
                 i, batch_cnt, prod_ready, sum_valid, i);
      end
    end
    drive(1'b1, 50, 1'b1, 1'b0);
    n_tests++;
    if (sum_valid !== 1'b1 || sum_out !== ACC_W'(36) || prod_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_sum: sum_valid=%b sum_out=%0d prod_ready=%b required 1/36/1",
               sum_valid, sum_out, prod_ready);
    end
    drive(1'b0, 0, 1'b1, 1'b0);
    n_tests++;
    if (sum_valid !== 1'b0 || batch_cnt !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL basic_no_bubble: sum_valid=%b batch_cnt=%0d required 0/1", sum_valid, batch_cnt);
    end
    flush();
  endtask

  task automatic test_max();
    for (int i = 0; i < 8; i++) drive(1'b1, 'hFFFF, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0);
    n_tests++;
    if (sum_valid !== 1'b1 || sum_out !== ACC_W'(524280) || batch_cnt !== '0) begin
      n_fail++;
      $display("FAIL max_sum: sum_valid=%b sum_out=%0d batch_cnt=%0d required 1/524280/0",
               sum_valid, sum_out, batch_cnt);
    end
    flush();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) drive(1'b1, i + 1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 10, 1'b0, 1'b0);
      n_tests++;
      if (prod_ready !== 1'b0 || sum_valid !== 1'b1 || sum_out !== ACC_W'(36)) begin
        n_fail++;
        $display("FAIL stall[%0d]: prod_ready=%b sum_valid=%b sum_out=%0d required 0/1/36",
                 i, prod_ready, sum_valid, sum_out);
      end
    end
    drive(1'b1, 10, 1'b1, 1'b0);
    n_tests++;
    if (prod_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: prod_ready=%b required 1", prod_ready);
    end
    drive(1'b1, 1, 1'b1, 1'b0);
    n_tests++;
    if (sum_valid !== 1'b0 || batch_cnt !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL stall_handoff: sum_valid=%b batch_cnt=%0d required 0/1", sum_valid, batch_cnt);
    end
    for (int i = 0; i < 6; i++) drive(1'b1, 1, 1'b1, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0);
    n_tests++;
    if (sum_valid !== 1'b1 || sum_out !== ACC_W'(17)) begin
      n_fail++;
      $display("FAIL stall_next_sum: sum_valid=%b sum_out=%0d required 1/17", sum_valid, sum_out);
    end
    flush();
  endtask

  task automatic test_clear();
    drive(1'b1, 100, 1'b1, 1'b0);
    drive(1'b1, 200, 1'b1, 1'b0);
    drive(1'b1, 300, 1'b1, 1'b0);
    drive(1'b1, 400, 1'b1, 1'b1);
    drive(1'b0, 0, 1'b1, 1'b0);
    n_tests++;
    if (batch_cnt !== '0 || sum_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_cnt: batch_cnt=%0d sum_valid=%b required 0/0", batch_cnt, sum_valid);
    end
    for (int i = 0; i < 8; i++) drive(1'b1, 1, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0);
    n_tests++;
    if (sum_valid !== 1'b1 || sum_out !== ACC_W'(8)) begin
      n_fail++;
      $display("FAIL clear_sum: sum_valid=%b sum_out=%0d required 1/8", sum_valid, sum_out);
    end
    flush();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 7, 1'b1, 1'b0);
    prod_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if (sum_valid !== 1'b0 || batch_cnt !== '0 || sum_out !== '0) begin
      n_fail++;
      $display("FAIL async_reset: sum_valid=%b batch_cnt=%0d sum_out=%0d required 0/0/0",
               sum_valid, batch_cnt, sum_out);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) drive(1'b1, 2, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0);
    n_tests++;
    if (sum_valid !== 1'b1 || sum_out !== ACC_W'(16)) begin
      n_fail++;
      $display("FAIL async_reset_sum: sum_valid=%b sum_out=%0d required 1/16", sum_valid, sum_out);
    end
    flush();
  endtask

  task automatic test_random();
    int start;
    int cycles;
    int errs;
    start  = m_batches;
    cycles = 0;
    errs   = 0;
    while (m_batches - start < 100 && cycles < 5000) begin
      drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 'hFFFF)),
            ($urandom_range(0, 4) < 3), 1'b0);
      cycles++;
      n_tests++;
      if (prod_ready !== (!m_hold || sum_ready) || sum_valid !== m_hold ||
          batch_cnt !== CNT_W'(m_parts.size()) || (m_hold && sum_out !== m_sum)) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: ready=%b valid=%b cnt=%0d sum=%0d required %b/%b/%0d/%0d",
                   cycles, prod_ready, sum_valid, batch_cnt, sum_out,
                   (!m_hold || sum_ready), m_hold, m_parts.size(), m_sum);
      end
    end
    n_tests++;
    if (m_batches - start < 100) begin
      n_fail++;
      $display("FAIL random_timeout: batches=%0d required 100", m_batches - start);
    end
    flush();
  endtask

  initial begin
    m_batches = 0;
    test_reset();
    test_basic();
    test_max();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
